// File: rtl/audio_fifo_ctl.sv
// rtl/audio_fifo_ctl.sv - stereo sample FIFO with prefill/underrun playback control for an I2S serializer
// Optional AUDIO_FIFO_UNF_CNT_EN adds a saturating 16-bit underrun event counter (o_unf_cnt).
module audio_fifo_ctl #(
    parameter int DEPTH_LOG2 = 4,
    parameter int PREFILL    = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_en,
    input  logic                     i_wr_en,
    input  logic signed [23:0]       i_wr_l,
    input  logic signed [23:0]       i_wr_r,
    output logic                     o_full,
    output logic [DEPTH_LOG2:0]      o_level,
    input  logic                     i_load,
    output logic signed [23:0]       o_l_data,
    output logic signed [23:0]       o_r_data,
    output logic                     o_playing,
    output logic                     o_ovf,
    output logic                     o_unf,
    input  logic                     i_clr_flags
`ifdef AUDIO_FIFO_UNF_CNT_EN
    ,
    output logic [15:0]              o_unf_cnt
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] P_ONE     = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   L_ONE     = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   L_DEPTH   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   L_PREFILL = (DEPTH_LOG2 + 1)'(PREFILL);

    typedef enum logic {S_FILL, S_PLAY} state_t;

    state_t                  r_state;
    logic [47:0]             r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_level;
    logic                    r_full;
    logic signed [23:0]      r_l_data;
    logic signed [23:0]      r_r_data;
    logic                    r_ovf;
    logic                    r_unf;

    logic                    w_wr;
    logic                    w_load;
    logic                    w_pop;
    logic                    w_ovf_evt;
    logic                    w_unf_evt;
    logic [47:0]             w_head;
    logic [DEPTH_LOG2:0]     w_level_nxt;

    assign w_wr      = i_en && i_wr_en && !r_full;
    assign w_ovf_evt = i_wr_en && r_full;
    assign w_load    = i_en && i_load;
    assign w_pop     = w_load && (((r_state == S_FILL) && (r_level >= L_PREFILL)) ||
                                  ((r_state == S_PLAY) && (r_level != '0)));
    assign w_unf_evt = w_load && (r_state == S_PLAY) && (r_level == '0);
    assign w_head    = r_mem[r_rd_ptr];

    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr, w_pop})
            2'b10:   w_level_nxt = r_level + L_ONE;
            2'b01:   w_level_nxt = r_level - L_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    // Sample storage is not reset; only accepted writes touch it.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {i_wr_l, i_wr_r};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_FILL;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_l_data <= '0;
            r_r_data <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            // A new event in the same cycle as a clear keeps the flag set.
            r_ovf <= w_ovf_evt || (r_ovf && !i_clr_flags);
            r_unf <= w_unf_evt || (r_unf && !i_clr_flags);

            if (!i_en) begin
                r_state  <= S_FILL;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
                r_full   <= 1'b0;
                r_l_data <= '0;
                r_r_data <= '0;
            end else begin
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + P_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + P_ONE;
                    r_l_data <= w_head[47:24];
                    r_r_data <= w_head[23:0];
                end
                r_level <= w_level_nxt;
                r_full  <= (w_level_nxt == L_DEPTH);

                case (r_state)
                    S_FILL: begin
                        if (w_pop) begin
                            r_state <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (w_unf_evt) begin
                            r_state  <= S_FILL;
                            r_l_data <= '0;
                            r_r_data <= '0;
                        end
                    end
                    default: r_state <= S_FILL;
                endcase
            end
        end
    end

`ifdef AUDIO_FIFO_UNF_CNT_EN
    logic [15:0] r_unf_cnt;

    // Clear plus underrun in one cycle leaves a count of one: the new event is kept.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_unf_cnt <= '0;
        end else if (w_unf_evt) begin
            if (i_clr_flags) begin
                r_unf_cnt <= 16'd1;
            end else if (r_unf_cnt != 16'hFFFF) begin
                r_unf_cnt <= r_unf_cnt + 16'd1;
            end
        end else if (i_clr_flags) begin
            r_unf_cnt <= '0;
        end
    end

    assign o_unf_cnt = r_unf_cnt;
`endif

    assign o_full    = r_full;
    assign o_level   = r_level;
    assign o_l_data  = r_l_data;
    assign o_r_data  = r_r_data;
    assign o_playing = (r_state == S_PLAY);
    assign o_ovf     = r_ovf;
    assign o_unf     = r_unf;

endmodule

// File: tb/tb_audio_fifo_ctl.sv
// tb/tb_audio_fifo_ctl.sv - directed scoreboard bench for audio_fifo_ctl (DEPTH_LOG2=4, PREFILL=8)
module tb_audio_fifo_ctl;

    localparam int DL2 = 4;
    localparam int PRE = 8;
    localparam int DEP = 1 << DL2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          wr_en = 1'b0;
    logic [23:0]   wr_l = '0;
    logic [23:0]   wr_r = '0;
    logic          load = 1'b0;
    logic          clr_flags = 1'b0;
    logic          full;
    logic [DL2:0]  level;
    logic [23:0]   l_data;
    logic [23:0]   r_data;
    logic          playing;
    logic          ovf;
    logic          unf;
`ifdef AUDIO_FIFO_UNF_CNT_EN
    logic [15:0]   unf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [47:0] sb[$];
    int          m_level;
    bit          m_play;
    logic [23:0] m_l;
    logic [23:0] m_r;
    bit          m_ovf;
    bit          m_unf;
    int          m_ucnt;

    audio_fifo_ctl #(.DEPTH_LOG2(DL2), .PREFILL(PRE)) dut (
        .i_clk(clk), .i_reset(reset), .i_en(en), .i_wr_en(wr_en),
        .i_wr_l(wr_l), .i_wr_r(wr_r), .o_full(full), .o_level(level),
        .i_load(load), .o_l_data(l_data), .o_r_data(r_data),
        .o_playing(playing), .o_ovf(ovf), .o_unf(unf), .i_clr_flags(clr_flags)
`ifdef AUDIO_FIFO_UNF_CNT_EN
        , .o_unf_cnt(unf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".level"},   48'(level),   48'(m_level));
        chk({tag, ".full"},    48'(full),    48'(m_level == DEP));
        chk({tag, ".playing"}, 48'(playing), 48'(m_play));
        chk({tag, ".l_data"},  48'(l_data),  48'(m_l));
        chk({tag, ".r_data"},  48'(r_data),  48'(m_r));
        chk({tag, ".ovf"},     48'(ovf),     48'(m_ovf));
        chk({tag, ".unf"},     48'(unf),     48'(m_unf));
`ifdef AUDIO_FIFO_UNF_CNT_EN
        chk({tag, ".unf_cnt"}, 48'(unf_cnt), 48'(m_ucnt));
`endif
    endtask

    task automatic model_reset();
        sb.delete();
        m_level = 0; m_play = 0; m_l = '0; m_r = '0;
        m_ovf = 0; m_unf = 0; m_ucnt = 0;
    endtask

    // One clock: update the model, drive the inputs, then compare after the edge.
    task automatic cyc(input string tag, input bit w, input logic [23:0] l, input logic [23:0] r,
                       input bit ld, input bit clr);
        bit          full_m;
        bit          popd;
        bit          ev_o;
        bit          ev_u;
        logic [47:0] e;
        full_m = (m_level == DEP);
        ev_o = w && full_m;
        ev_u = 0;
        popd = 0;
        if (!en) begin
            sb.delete();
            m_level = 0; m_play = 0; m_l = '0; m_r = '0;
        end else begin
            if (ld) begin
                if (!m_play && m_level >= PRE) begin
                    popd = 1; m_play = 1;
                end else if (m_play && m_level > 0) begin
                    popd = 1;
                end else if (m_play) begin
                    ev_u = 1; m_play = 0; m_l = '0; m_r = '0;
                end
            end
            if (popd) begin
                e = sb.pop_front();
                m_l = e[47:24]; m_r = e[23:0];
                m_level--;
            end
            if (w && !full_m) begin
                sb.push_back({l, r});
                m_level++;
            end
        end
        m_ovf = ev_o || (m_ovf && !clr);
        m_unf = ev_u || (m_unf && !clr);
        if (ev_u) m_ucnt = clr ? 1 : ((m_ucnt < 16'hFFFF) ? m_ucnt + 1 : m_ucnt);
        else if (clr) m_ucnt = 0;

        wr_en = w; wr_l = l; wr_r = r; load = ld; clr_flags = clr;
        @(posedge clk);
        #1;
        wr_en = 0; load = 0; clr_flags = 0;
        chk_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1; wr_en = 1; load = 1; clr_flags = 0;
        wr_l = 24'hABCDEF; wr_r = 24'h123456;
        @(posedge clk);
        #1;
        reset = 0; wr_en = 0; load = 0;
        model_reset();
        chk_all(tag);
    endtask

    initial begin
        model_reset();
        en = 0;
        do_reset("por");
        en = 1;

        // Prefill: 7 entries are not enough, the 8th lets the next load start playback
        for (int i = 1; i <= 7; i++) cyc("pre_wr", 1, 24'(i), ~24'(i), 0, 0);
        cyc("pre_ld7", 0, '0, '0, 1, 0);
        chk("pre_ld7.idle", 48'({playing, l_data}), 48'(0));
        cyc("pre_wr8", 1, 24'(8), ~24'(8), 0, 0);
        cyc("pre_ld8", 0, '0, '0, 1, 0);
        chk("pre_ld8.first", 48'({playing, l_data, r_data}), {23'd0, 1'b1, 24'h000001, 24'hFFFFFE});

        // Flush via en=0, then fill to full and overflow with a 17th write
        en = 0;
        cyc("flush", 0, '0, '0, 1, 0);
        en = 1;
        for (int i = 1; i <= 16; i++) cyc("ord_wr", 1, 24'(i), ~24'(i), 0, 0);
        chk("ovf.full16", 48'({full, level}), 48'({1'b1, 5'd16}));
        cyc("ovf_wr17", 1, 24'(17), ~24'(17), 0, 0);
        chk("ovf.flag", 48'({ovf, level}), 48'({1'b1, 5'd16}));

        // Ordering: 16 loads drain in write order
        for (int i = 1; i <= 16; i++) begin
            cyc("ord_ld", 0, '0, '0, 1, 0);
            chk("ord.seq", 48'({l_data, r_data}), {24'(i), ~24'(i)});
        end
        chk("ord.empty", 48'({level, unf}), 48'(0));

        // Underrun on a load with an empty FIFO in PLAY
        cyc("unf_ld", 0, '0, '0, 1, 0);
        chk("unf.flag", 48'({unf, playing, l_data}), {23'd0, 1'b1, 1'b0, 24'd0});
        cyc("clr", 0, '0, '0, 0, 1);

        // Simultaneous write+load at full: write dropped, pop proceeds
        for (int i = 0; i < 16; i++) cyc("sim_wr", 1, 24'h100 + 24'(i), 24'h200 + 24'(i), 0, 0);
        cyc("sim_full", 1, 24'h7FFFFF, 24'h800000, 1, 0);
        chk("sim.full_pop", 48'({ovf, level}), 48'({1'b1, 5'd15}));
        for (int i = 0; i < 10; i++) cyc("sim_drain", 0, '0, '0, 1, 0);
        cyc("sim_lvl5", 1, 24'h00A5A5, 24'hFF5A5A, 1, 0);
        chk("sim.level5", 48'(level), 48'(5));

        // Reset mid-play at level 9
        for (int i = 0; i < 4; i++) cyc("rst_wr", 1, 24'h300 + 24'(i), 24'h400 + 24'(i), 0, 0);
        chk("rst.pre_level", 48'({playing, level}), 48'({1'b1, 5'd9}));
        do_reset("rst_mid");

        // en=0 mid-play at level 9
        en = 1;
        for (int i = 0; i < 9; i++) cyc("en_wr", 1, 24'h500 + 24'(i), 24'h600 + 24'(i), 0, 0);
        cyc("en_ld", 1, 24'h509, 24'h609, 1, 0);
        chk("en.pre_level", 48'({playing, level}), 48'({1'b1, 5'd9}));
        en = 0;
        cyc("en_off", 0, '0, '0, 1, 0);
        chk("en.off", 48'({playing, level, l_data}), 48'(0));
        en = 1;

        // Clear coinciding with underrun: set wins
        for (int i = 0; i < 8; i++) cyc("cu_wr", 1, 24'h700 + 24'(i), 24'h800 + 24'(i), 0, 0);
        for (int i = 0; i < 8; i++) cyc("cu_ld", 0, '0, '0, 1, 0);
        cyc("cu_both", 0, '0, '0, 1, 1);
        chk("cu.unf_kept", 48'({unf, playing}), 48'(2'b10));
        cyc("cu_clr", 0, '0, '0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_fifo_ctl.md
AUDIO_FIFO_CTL -- requirements
Module: audio_fifo_ctl

Interface
REQ-001 Parameter DEPTH_LOG2, default 4: FIFO depth is 2^DEPTH_LOG2 stereo entries.
REQ-002 Parameter PREFILL, default 8: entries required before playback starts, range 1..2^DEPTH_LOG2.
REQ-003 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  system POR; synchronous, active-high.
REQ-005 en  input  1  playback enable; low flushes the FIFO and holds idle.
REQ-006 wr_en  input  1  producer write strobe, one entry per cycle.
REQ-007 wr_l, wr_r  input  24 each  signed left and right samples to write.
REQ-008 full  output  1  FIFO full; writes are rejected while high.
REQ-009 level  output  DEPTH_LOG2+1  current FIFO entry count.
REQ-010 load  input  1  one-cycle sample-rate strobe from the I2S serializer.
REQ-011 l_data, r_data  output  24 each  signed samples presented to the serializer.
REQ-012 playing  output  1  high while in state PLAY.
REQ-013 ovf, unf  output  1 each  sticky overflow and underrun flags.
REQ-014 clr_flags  input  1  clears ovf and unf.

Function
REQ-015 Storage SHALL be a 2^DEPTH_LOG2 x 48-bit circular buffer {l,r}, with read and write pointers wrapping modulo depth.
REQ-016 A write SHALL be accepted when wr_en=1, full=0 and en=1; full SHALL be registered and equal (level==2^DEPTH_LOG2).
REQ-017 When wr_en=1 and full=1, the write SHALL be dropped, ovf SHALL be set, and the FIFO SHALL be unchanged, even if a pop occurs in the same cycle.
REQ-018 States SHALL be FILL and PLAY; FILL is entered on reset, on en=0, and on underrun.
REQ-019 In FILL, l_data and r_data SHALL be forced to 0 and load SHALL NOT pop.
REQ-020 FILL SHALL transition to PLAY on a load cycle where level>=PREFILL; that same load SHALL pop the head entry.
REQ-021 In PLAY, a load with level>0 SHALL pop the head; the popped {l,r} SHALL appear on l_data/r_data at the next edge and hold until the next pop or zeroing. The serializer captures the prior value on the load edge, giving one frame of latency.
REQ-022 In PLAY, a load with level==0 SHALL set unf, zero l_data/r_data at the next edge, and transition to FILL.
REQ-023 A simultaneous accepted write and pop SHALL leave level unchanged; the written entry SHALL be valid for a later pop.
REQ-024 en=0 SHALL, at the next edge, reset both pointers and level to 0, zero the outputs, and enter FILL; ovf and unf SHALL be retained.
REQ-025 clr_flags SHALL clear ovf and unf at the next edge unless a new overflow or underrun occurs in that cycle, in which case set wins.
REQ-026 Load pulses arriving while en=0 SHALL be ignored.

Reset
REQ-027 On reset=1: pointers=0, level=0, full=0, state=FILL, playing=0, l_data=0, r_data=0, ovf=0, unf=0; reset SHALL override every other input, including mid-PLAY.
REQ-028 Stored FIFO data need not be cleared by reset.

Configuration
REQ-029 With AUDIO_FIFO_UNF_CNT_EN defined, the block SHALL add output unf_cnt (16 bits). It SHALL increment on every underrun event, saturate at 16'hFFFF, be cleared by reset and clr_flags, and apply the same set-wins rule as REQ-025.
REQ-030 Without AUDIO_FIFO_UNF_CNT_EN, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Prefill: en=1, write 7 entries, pulse load → playing=0, outputs 0; write the 8th entry, pulse load → playing=1 and the first entry appears on l_data/r_data one cycle after load.
REQ-032 Ordering: write L=24'h000001..000010 and R=~L, load 16 times → outputs appear in write order, level reaches 0, unf=0.
REQ-033 Overflow: write 17 entries back-to-back with DEPTH_LOG2=4 → full=1 after the 16th, 17th dropped, ovf=1, level=16.
REQ-034 Underrun: in PLAY with level=0, pulse load → unf=1, outputs 0 next cycle, playing=0; with AUDIO_FIFO_UNF_CNT_EN, unf_cnt=1.
REQ-035 Simultaneous: level=16, assert wr_en and load together → write dropped, ovf=1, level=15; at level=5, wr_en+load → level stays 5.
REQ-036 Reset/en mid-play: assert reset or en=0 during PLAY with level=9 → next cycle level=0, state FILL, outputs 0; clr_flags together with an underrun → unf stays 1.
